// File: rtl/mdio_master_if.sv
// Command/response bundle between a requester and the MDIO management master.
// The requester uses the master modport; mdio_master takes the slave side.
interface mdio_master_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [4:0]  cmd_phy_addr;
    logic [4:0]  cmd_reg_addr;
    logic [15:0] cmd_wdata;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output cmd_valid, cmd_write, cmd_phy_addr, cmd_reg_addr, cmd_wdata,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  cmd_valid, cmd_write, cmd_phy_addr, cmd_reg_addr, cmd_wdata,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/mdio_master.sv
// Clause-22 MDIO master: serialises one 64-bit management frame per command,
// generates MDC from clk, and returns read data / turnaround error on completion.
module mdio_master #(
    parameter int CLK_DIV = 20
) (
    input  logic               clk,
    input  logic               rstn,
    mdio_master_if.slave       bus,
    output logic               mdc,
    output logic               mdio_o,
    output logic               mdio_oe,
    input  logic               mdio_i
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    state_e      state_q,     state_d;
    logic [5:0]  bit_q,       bit_d;
    logic [7:0]  div_q,       div_d;
    logic [63:0] frame_q,     frame_d;
    logic        write_q,     write_d;
    logic [15:0] rd_sh_q,     rd_sh_d;
    logic        err_sh_q,    err_sh_d;
    logic        mdc_q,       mdc_d;
    logic        mdio_oe_q,   mdio_oe_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [15:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_err_q,   rsp_err_d;

    always_comb begin
        state_d     = state_q;
        bit_d       = bit_q;
        div_d       = div_q;
        frame_d     = frame_q;
        write_d     = write_q;
        rd_sh_d     = rd_sh_q;
        err_sh_d    = err_sh_q;
        mdc_d       = mdc_q;
        mdio_oe_d   = mdio_oe_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;

        case (state_q)
            IDLE: begin
                if (bus.cmd_valid) begin
                    state_d   = SHIFT;
                    bit_d     = 6'd0;
                    div_d     = 8'd0;
                    write_d   = bus.cmd_write;
                    rd_sh_d   = 16'h0000;
                    err_sh_d  = 1'b0;
                    mdc_d     = 1'b0;
                    mdio_oe_d = 1'b1;
                    // Read TA/data positions hold 1s; they are never driven onto the pad.
                    frame_d   = {32'hFFFF_FFFF, 2'b01,
                                 bus.cmd_write ? 2'b01 : 2'b10,
                                 bus.cmd_phy_addr, bus.cmd_reg_addr,
                                 bus.cmd_write ? 2'b10 : 2'b11,
                                 bus.cmd_write ? bus.cmd_wdata : 16'hFFFF};
                end
            end
            SHIFT: begin
                if (div_q != DIV_LAST) begin
                    div_d = div_q + 8'd1;
                end else begin
                    div_d = 8'd0;
                    if (!mdc_q) begin
                        // Rising MDC edge: the PHY's bit is sampled here.
                        mdc_d = 1'b1;
                        if (!write_q && bit_q == 6'd47) err_sh_d = mdio_i;
                        if (!write_q && bit_q >= 6'd48) rd_sh_d = {rd_sh_q[14:0], mdio_i};
                    end else begin
                        mdc_d = 1'b0;
                        if (bit_q == 6'd63) begin
                            state_d     = DONE;
                            frame_d     = '1;
                            mdio_oe_d   = 1'b0;
                            rsp_valid_d = 1'b1;
                            rsp_rdata_d = rd_sh_q;
                            rsp_err_d   = err_sh_q;
                        end else begin
                            bit_d     = bit_q + 6'd1;
                            frame_d   = {frame_q[62:0], 1'b1};
                            mdio_oe_d = write_q || (bit_q < 6'd45);
                        end
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: reset is synchronous to match the rest of the codebase; every flop,
    // the frame register included, is cleared so an aborted frame leaves nothing behind.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= IDLE;
            bit_q       <= 6'd0;
            div_q       <= 8'd0;
            frame_q     <= '1;
            write_q     <= 1'b0;
            rd_sh_q     <= 16'h0000;
            err_sh_q    <= 1'b0;
            mdc_q       <= 1'b0;
            mdio_oe_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 16'h0000;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_q       <= bit_d;
            div_q       <= div_d;
            frame_q     <= frame_d;
            write_q     <= write_d;
            rd_sh_q     <= rd_sh_d;
            err_sh_q    <= err_sh_d;
            mdc_q       <= mdc_d;
            mdio_oe_q   <= mdio_oe_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign bus.cmd_ready = (state_q == IDLE);
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;
    assign mdc           = mdc_q;
    assign mdio_o        = frame_q[63];
    assign mdio_oe       = mdio_oe_q;

endmodule

// File: tb/tb_mdio_master.sv
// Bench for mdio_master: two instances (CLK_DIV 4 and 2) checked every cycle against
// a cycle-count model of the frame timing, plus directed literal checks.
module tb_mdio_master;

    localparam int DIV0 = 4;
    localparam int DIV1 = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn      [2];
    logic        cmd_valid [2];
    logic        cmd_write [2];
    logic [4:0]  cmd_phy   [2];
    logic [4:0]  cmd_reg   [2];
    logic [15:0] cmd_wdata [2];
    logic        mdio_i    [2];
    logic        rdy       [2];
    logic        rsp_valid [2];
    logic [15:0] rsp_rdata [2];
    logic        rsp_err   [2];
    logic        mdc       [2];
    logic        mdio_o    [2];
    logic        mdio_oe   [2];

    mdio_master_if bus0 ();
    mdio_master_if bus1 ();

    assign bus0.cmd_valid    = cmd_valid[0];
    assign bus0.cmd_write    = cmd_write[0];
    assign bus0.cmd_phy_addr = cmd_phy[0];
    assign bus0.cmd_reg_addr = cmd_reg[0];
    assign bus0.cmd_wdata    = cmd_wdata[0];
    assign rdy[0]            = bus0.cmd_ready;
    assign rsp_valid[0]      = bus0.rsp_valid;
    assign rsp_rdata[0]      = bus0.rsp_rdata;
    assign rsp_err[0]        = bus0.rsp_err;

    assign bus1.cmd_valid    = cmd_valid[1];
    assign bus1.cmd_write    = cmd_write[1];
    assign bus1.cmd_phy_addr = cmd_phy[1];
    assign bus1.cmd_reg_addr = cmd_reg[1];
    assign bus1.cmd_wdata    = cmd_wdata[1];
    assign rdy[1]            = bus1.cmd_ready;
    assign rsp_valid[1]      = bus1.rsp_valid;
    assign rsp_rdata[1]      = bus1.rsp_rdata;
    assign rsp_err[1]        = bus1.rsp_err;

    mdio_master #(.CLK_DIV(DIV0)) dut0 (
        .clk(clk), .rstn(rstn[0]), .bus(bus0),
        .mdc(mdc[0]), .mdio_o(mdio_o[0]), .mdio_oe(mdio_oe[0]), .mdio_i(mdio_i[0])
    );

    mdio_master #(.CLK_DIV(DIV1)) dut1 (
        .clk(clk), .rstn(rstn[1]), .bus(bus1),
        .mdc(mdc[1]), .mdio_o(mdio_o[1]), .mdio_oe(mdio_oe[1]), .mdio_i(mdio_i[1])
    );

    function automatic int dv(input int i);
        return (i == 0) ? DIV0 : DIV1;
    endfunction

    // Reference model: one record per instance, timing derived from the accept cycle.
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;
    bit          chk_en = 1'b0;
    bit          m_busy      [2] = '{1'b0, 1'b0};
    int          m_s0        [2] = '{0, 0};
    bit          m_write     [2] = '{1'b0, 1'b0};
    logic [63:0] m_frame     [2] = '{64'h0, 64'h0};
    bit          m_present   [2] = '{1'b0, 1'b0};
    bit          m_ta        [2] = '{1'b0, 1'b0};
    logic [15:0] m_rdata     [2] = '{16'h0, 16'h0};
    logic [15:0] m_pend_rd   [2] = '{16'h0, 16'h0};
    bit          m_pend_err  [2] = '{1'b0, 1'b0};
    logic [15:0] m_exp_rdata [2] = '{16'h0, 16'h0};
    bit          m_exp_err   [2] = '{1'b0, 1'b0};
    bit          nx_present  [2] = '{1'b0, 1'b0};
    bit          nx_ta       [2] = '{1'b0, 1'b0};
    logic [15:0] nx_rdata    [2] = '{16'h0, 16'h0};

    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int i = 0; i < 2; i++) begin
            if (!rstn[i]) begin
                m_busy[i]      <= 1'b0;
                m_exp_rdata[i] <= 16'h0000;
                m_exp_err[i]   <= 1'b0;
            end else begin
                if (m_busy[i] && cyc + 1 == m_s0[i] + 128 * dv(i)) begin
                    m_exp_rdata[i] <= m_pend_rd[i];
                    m_exp_err[i]   <= m_pend_err[i];
                end
                if ((!m_busy[i] || cyc > m_s0[i] + 128 * dv(i)) && cmd_valid[i]) begin
                    m_busy[i]     <= 1'b1;
                    m_s0[i]       <= cyc + 1;
                    m_write[i]    <= cmd_write[i];
                    m_frame[i]    <= {32'hFFFF_FFFF, 2'b01, cmd_write[i] ? 2'b01 : 2'b10,
                                      cmd_phy[i], cmd_reg[i], 2'b10, cmd_wdata[i]};
                    m_present[i]  <= nx_present[i];
                    m_ta[i]       <= nx_ta[i];
                    m_rdata[i]    <= nx_rdata[i];
                    m_pend_rd[i]  <= cmd_write[i] ? 16'h0000 : (nx_present[i] ? nx_rdata[i] : 16'hFFFF);
                    m_pend_err[i] <= !cmd_write[i] && (!nx_present[i] || nx_ta[i]);
                end else if (m_busy[i] && cyc > m_s0[i] + 128 * dv(i)) begin
                    m_busy[i] <= 1'b0;
                end
            end
        end
    end

    // PHY: valid bit only in the cycle before the MDC rise, inverted elsewhere.
    function automatic logic phy_bit(input int k, input int d, input bit present,
                                     input bit ta, input logic [15:0] rd);
        int  b;
        bit  rise;
        logic v;
        if (!present) return 1'b1;
        b    = k / (2 * d);
        rise = ((k % (2 * d)) == d - 1);
        if (b == 47)      v = ta;
        else if (b >= 48) v = rd[63 - b];
        else              return 1'b1;
        return rise ? v : ~v;
    endfunction

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            mdio_i[i] = 1'b1;
            if (m_busy[i] && !m_write[i] && cyc >= m_s0[i] && cyc < m_s0[i] + 128 * dv(i))
                mdio_i[i] = phy_bit(cyc - m_s0[i], dv(i), m_present[i], m_ta[i], m_rdata[i]);
        end
    end

    task automatic check(input string name, input int i, input logic [63:0] act,
                         input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s dut%0d cyc=%0d got=%h want=%h", name, i, cyc, act, exp);
        end
    endtask

    // DUT-side observations used by the directed literal checks.
    int          acc_cyc   [2] = '{0, 0};
    int          acc_count [2] = '{0, 0};
    int          rsp_cyc   [2] = '{0, 0};
    int          rsp_count [2] = '{0, 0};
    int          oe_fall   [2] = '{-1, -1};
    bit          oe_all    [2] = '{1'b0, 1'b0};
    logic [63:0] cap       [2] = '{64'h0, 64'h0};

    task automatic compare_one(input int i);
        int d, k, b;
        bit active, in_shift, done_c, e_mdc, e_oe;
        d        = dv(i);
        k        = cyc - m_s0[i];
        b        = (k >= 0) ? k / (2 * d) : 0;
        active   = m_busy[i] && cyc >= m_s0[i] && cyc <= m_s0[i] + 128 * d;
        in_shift = active && cyc < m_s0[i] + 128 * d;
        done_c   = active && cyc == m_s0[i] + 128 * d;
        e_mdc    = in_shift && ((k % (2 * d)) >= d);
        e_oe     = in_shift && (m_write[i] || b <= 45);
        check("cmd_ready", i, rdy[i], !active);
        check("rsp_valid", i, rsp_valid[i], done_c);
        check("mdc", i, mdc[i], e_mdc);
        check("mdio_oe", i, mdio_oe[i], e_oe);
        if (e_oe)         check("mdio_o", i, mdio_o[i], m_frame[i][63 - b]);
        else if (!active) check("mdio_o_idle", i, mdio_o[i], 1'b1);
        check("rsp_rdata", i, rsp_rdata[i], m_exp_rdata[i]);
        check("rsp_err", i, rsp_err[i], m_exp_err[i]);

        if (cmd_valid[i] && rdy[i]) begin
            acc_cyc[i] = cyc;
            acc_count[i]++;
        end
        if (rsp_valid[i]) begin
            rsp_cyc[i] = cyc;
            rsp_count[i]++;
        end
        if (in_shift) begin
            if (k == 0) begin
                cap[i]     = 64'h0;
                oe_all[i]  = 1'b1;
                oe_fall[i] = -1;
            end
            if (k % (2 * d) == 0) cap[i] = {cap[i][62:0], mdio_o[i]};
            oe_all[i] = oe_all[i] & mdio_oe[i];
            if (!mdio_oe[i] && oe_fall[i] < 0) oe_fall[i] = cyc;
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) for (int i = 0; i < 2; i++) compare_one(i);
        end
    end

    task automatic issue(input int i, input bit w, input logic [4:0] p, input logic [4:0] r,
                         input logic [15:0] wd, input bit present, input bit ta,
                         input logic [15:0] rd, input bit hold);
        int n;
        @(posedge clk); #1;
        cmd_write[i]  = w;
        cmd_phy[i]    = p;
        cmd_reg[i]    = r;
        cmd_wdata[i]  = wd;
        nx_present[i] = present;
        nx_ta[i]      = ta;
        nx_rdata[i]   = rd;
        cmd_valid[i]  = 1'b1;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!(m_busy[i] && m_s0[i] == cyc) && n < 3000);
        check("accept_timeout", i, (n < 3000) ? 64'd1 : 64'd0, 64'd1);
        if (!hold) cmd_valid[i] = 1'b0;
    endtask

    task automatic wait_done(input int i);
        int n;
        n = 0;
        while (m_busy[i] && cyc <= m_s0[i] + 128 * dv(i) && n < 5000) begin
            @(posedge clk); #1;
            n++;
        end
        check("done_timeout", i, (n < 5000) ? 64'd1 : 64'd0, 64'd1);
    endtask

    task automatic pulse_reset(input int i);
        rstn[i] = 1'b0;
        @(posedge clk); #1;
        rstn[i] = 1'b1;
    endtask

    task automatic run_random(input int count);
        for (int n = 0; n < count; n++) begin
            int i;
            i = int'($urandom_range(0, 1));
            issue(i, 1'($urandom), 5'($urandom), 5'($urandom), 16'($urandom),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0, 16'($urandom), 1'b0);
            cmd_write[i] = 1'($urandom);
            cmd_phy[i]   = 5'($urandom);
            cmd_reg[i]   = 5'($urandom);
            cmd_wdata[i] = 16'($urandom);
            if ($urandom_range(0, 7) == 0) begin
                repeat ($urandom_range(0, 128 * dv(i) - 2)) @(posedge clk);
                #1;
                pulse_reset(i);
            end
            wait_done(i);
            repeat ($urandom_range(0, 5)) @(posedge clk);
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cnt0, acc0, target, n;
        for (int i = 0; i < 2; i++) begin
            rstn[i] = 1'b0; cmd_valid[i] = 1'b0; cmd_write[i] = 1'b0;
            cmd_phy[i] = 5'h0; cmd_reg[i] = 5'h0; cmd_wdata[i] = 16'h0;
        end
        repeat (3) @(posedge clk);
        #1;
        rstn[0] = 1'b1;
        rstn[1] = 1'b1;
        chk_en  = 1'b1;
        for (int i = 0; i < 2; i++) begin
            check("rst_ready", i, rdy[i], 1'b1);
            check("rst_mdc", i, mdc[i], 1'b0);
            check("rst_mdio_o", i, mdio_o[i], 1'b1);
            check("rst_oe", i, mdio_oe[i], 1'b0);
            check("rst_rsp_valid", i, rsp_valid[i], 1'b0);
            check("rst_rdata", i, rsp_rdata[i], 16'h0000);
            check("rst_err", i, rsp_err[i], 1'b0);
        end

        // Write PHY 1 / REG 0 / 16'h1140.
        issue(0, 1'b1, 5'h01, 5'h00, 16'h1140, 1'b0, 1'b0, 16'h0, 1'b0);
        wait_done(0);
        check("wr_stream", 0, cap[0], 64'hFFFF_FFFF_5082_1140);
        check("wr_oe_all", 0, oe_all[0], 1'b1);
        check("wr_latency", 0, rsp_cyc[0] - acc_cyc[0], 64'd513);
        check("wr_rdata", 0, rsp_rdata[0], 16'h0000);
        check("wr_err", 0, rsp_err[0], 1'b0);

        // Read PHY 3 / REG 1 with PHY answering 16'h796D.
        issue(0, 1'b0, 5'h03, 5'h01, 16'hABCD, 1'b1, 1'b0, 16'h796D, 1'b0);
        wait_done(0);
        check("rd_rdata", 0, rsp_rdata[0], 16'h796D);
        check("rd_err", 0, rsp_err[0], 1'b0);
        check("rd_oe_fall", 0, oe_fall[0] - acc_cyc[0], 64'd369);

        // Read with no PHY on the bus.
        issue(0, 1'b0, 5'h1F, 5'h02, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0);
        wait_done(0);
        check("nophy_rdata", 0, rsp_rdata[0], 16'hFFFF);
        check("nophy_err", 0, rsp_err[0], 1'b1);

        // Abort a write at bit 20 with a one-cycle reset.
        cnt0 = rsp_count[0];
        issue(0, 1'b1, 5'h07, 5'h09, 16'h5A5A, 1'b0, 1'b0, 16'h0, 1'b0);
        target = m_s0[0] + 20 * 2 * DIV0 + 3;
        n = 0;
        while (cyc < target && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        pulse_reset(0);
        check("abort_mdc", 0, mdc[0], 1'b0);
        check("abort_oe", 0, mdio_oe[0], 1'b0);
        check("abort_ready", 0, rdy[0], 1'b1);
        check("abort_rdata", 0, rsp_rdata[0], 16'h0000);
        repeat (600) @(posedge clk);
        #1;
        check("abort_no_rsp", 0, rsp_count[0], cnt0);
        issue(0, 1'b1, 5'h07, 5'h09, 16'h5A5A, 1'b0, 1'b0, 16'h0, 1'b0);
        wait_done(0);
        check("after_abort_rsp", 0, rsp_count[0], cnt0 + 1);

        // Back-to-back with cmd_valid held high.
        acc0 = acc_count[0];
        issue(0, 1'b1, 5'h02, 5'h04, 16'hBEEF, 1'b0, 1'b0, 16'h0, 1'b1);
        issue(0, 1'b0, 5'h02, 5'h05, 16'h0, 1'b1, 1'b0, 16'h1234, 1'b0);
        check("b2b_accept", 0, acc_cyc[0], rsp_cyc[0] + 1);
        wait_done(0);
        check("b2b_accepts", 0, acc_count[0] - acc0, 64'd2);
        check("b2b_rdata", 0, rsp_rdata[0], 16'h1234);

        // CLK_DIV = 2 read.
        issue(1, 1'b0, 5'h0A, 5'h11, 16'h0, 1'b1, 1'b0, 16'hC3A5, 1'b0);
        wait_done(1);
        check("div2_latency", 1, rsp_cyc[1] - acc_cyc[1], 64'd257);
        check("div2_rdata", 1, rsp_rdata[1], 16'hC3A5);
        check("div2_err", 1, rsp_err[1], 1'b0);

        run_random(48);

        repeat (4) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
